// File: rtl/cpu_memory_stage.sv
// CPU memory pipeline stage.
// Takes the execute result record, performs loads, stores and cache flushes
// on the data bus, and publishes a tagged writeback record. A new operation
// is recognised by its tag differing from the last retired tag while idle.
module cpu_memory_stage #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    output logic                 o_fault,
    output logic                 o_busy,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [4:0]           i_inst_rd,
    input  logic [31:0]          i_rd,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic                 i_mem_flush,
    input  logic [2:0]           i_mem_width,
    input  logic                 i_mem_signed,
    input  logic [31:0]          i_mem_address,
    output logic                 o_bus_request,
    output logic                 o_bus_rw,
    output logic                 o_bus_flush,
    output logic [31:0]          o_bus_address,
    output logic [3:0]           o_bus_byte_enable,
    output logic [31:0]          o_bus_wdata,
    input  logic                 i_bus_ready,
    input  logic [31:0]          i_bus_rdata,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [4:0]           o_inst_rd,
    output logic [31:0]          o_rd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                 r_state;

    // Writeback record and sticky fault
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [4:0]             r_inst_rd;
    logic [31:0]            r_rd;
    logic                   r_fault;

    // Bus request registers, held stable for the whole transaction
    logic                   r_bus_request;
    logic                   r_bus_rw;
    logic                   r_bus_flush;
    logic [31:0]            r_bus_address;
    logic [3:0]             r_bus_byte_enable;
    logic [31:0]            r_bus_wdata;

    // Copy of the execute record taken when a bus operation starts
    logic [TAG_WIDTH-1:0]   r_lat_tag;
    logic [4:0]             r_lat_inst_rd;
    logic [31:0]            r_lat_rd;
    logic [2:0]             r_lat_width;
    logic                   r_lat_signed;
    logic [1:0]             r_lat_off;

    logic                   w_new_op;
    logic                   w_mem_op;
    logic                   w_misaligned;

    // Width/offset legality: bytes are always legal, halves need an even
    // address, words need a word address; any other width is illegal.
    function automatic logic f_misaligned(input logic [2:0] width, input logic [1:0] off);
        logic bad;
        case (width)
            3'd1:    bad = 1'b0;
            3'd2:    bad = off[0];
            3'd4:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte-lane enables for a store of the given width at the given offset.
    function automatic logic [3:0] f_byte_enable(input logic [2:0] width, input logic [1:0] off);
        logic [3:0] be;
        case (width)
            3'd1:    be = 4'b0001 << off;
            3'd2:    be = 4'b0011 << off;
            3'd4:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the enables pick the right copy.
    function automatic logic [31:0] f_wdata(input logic [2:0] width, input logic [31:0] data);
        logic [31:0] wd;
        case (width)
            3'd1:    wd = {4{data[7:0]}};
            3'd2:    wd = {2{data[15:0]}};
            3'd4:    wd = data;
            default: wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] f_load(input logic [2:0] width, input logic [1:0] off,
                                           input logic sgn, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] ld;
        sh = rdata >> {off, 3'b000};
        case (width)
            3'd1:    ld = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h00_0000, sh[7:0]};
            3'd2:    ld = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            3'd4:    ld = rdata;
            default: ld = 32'h0000_0000;
        endcase
        return ld;
    endfunction

    // New-op detection, stall generation and alignment check on the live inputs
    always_comb begin
        w_new_op     = (r_state == S_IDLE) && (i_tag != r_tag);
        w_mem_op     = i_mem_read || i_mem_write || i_mem_flush;
        w_misaligned = f_misaligned(i_mem_width, i_mem_address[1:0]);
        o_busy       = (r_state != S_IDLE) || (w_new_op && w_mem_op);
    end

    // Stage FSM: issue bus transactions, hold them until ready, retire records
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state           <= S_IDLE;
            r_tag             <= '0;
            r_inst_rd         <= 5'd0;
            r_rd              <= 32'h0000_0000;
            r_fault           <= 1'b0;
            r_bus_request     <= 1'b0;
            r_bus_rw          <= 1'b0;
            r_bus_flush       <= 1'b0;
            r_bus_address     <= 32'h0000_0000;
            r_bus_byte_enable <= 4'b0000;
            r_bus_wdata       <= 32'h0000_0000;
            r_lat_tag         <= '0;
            r_lat_inst_rd     <= 5'd0;
            r_lat_rd          <= 32'h0000_0000;
            r_lat_width       <= 3'd0;
            r_lat_signed      <= 1'b0;
            r_lat_off         <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_new_op) begin
                        if (!w_mem_op) begin
                            // Non-memory result: retire next cycle, no bus activity
                            r_tag     <= i_tag;
                            r_inst_rd <= i_inst_rd;
                            r_rd      <= i_rd;
                        end else if (w_misaligned) begin
                            // Retire with a zero result so the pipeline keeps moving
                            r_fault   <= 1'b1;
                            r_tag     <= i_tag;
                            r_inst_rd <= i_inst_rd;
                            r_rd      <= 32'h0000_0000;
                        end else begin
                            r_lat_tag     <= i_tag;
                            r_lat_inst_rd <= i_inst_rd;
                            r_lat_rd      <= i_rd;
                            r_lat_width   <= i_mem_width;
                            r_lat_signed  <= i_mem_signed;
                            r_lat_off     <= i_mem_address[1:0];
                            r_bus_request <= 1'b1;
                            r_bus_address <= {i_mem_address[31:2], 2'b00};
                            if (i_mem_write) begin
                                r_state           <= S_WRITE;
                                r_bus_rw          <= 1'b1;
                                r_bus_flush       <= 1'b0;
                                r_bus_byte_enable <= f_byte_enable(i_mem_width, i_mem_address[1:0]);
                                r_bus_wdata       <= f_wdata(i_mem_width, i_rd);
                            end else if (i_mem_read) begin
                                r_state           <= S_READ;
                                r_bus_rw          <= 1'b0;
                                r_bus_flush       <= 1'b0;
                                r_bus_byte_enable <= 4'b0000;
                                r_bus_wdata       <= 32'h0000_0000;
                            end else begin
                                r_state           <= S_FLUSH;
                                r_bus_rw          <= 1'b0;
                                r_bus_flush       <= 1'b1;
                                r_bus_byte_enable <= 4'b0000;
                                r_bus_wdata       <= 32'h0000_0000;
                            end
                        end
                    end
                end
                S_READ, S_WRITE, S_FLUSH: begin
                    if (i_bus_ready) begin
                        r_state           <= S_IDLE;
                        r_bus_request     <= 1'b0;
                        r_bus_rw          <= 1'b0;
                        r_bus_flush       <= 1'b0;
                        r_bus_address     <= 32'h0000_0000;
                        r_bus_byte_enable <= 4'b0000;
                        r_bus_wdata       <= 32'h0000_0000;
                        r_tag             <= r_lat_tag;
                        r_inst_rd         <= r_lat_inst_rd;
                        // Stores and flushes hand the store data on, as execute does
                        if (r_state == S_READ) begin
                            r_rd <= f_load(r_lat_width, r_lat_off, r_lat_signed, i_bus_rdata);
                        end else begin
                            r_rd <= r_lat_rd;
                        end
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_bus_request <= 1'b0;
                end
            endcase
        end
    end

    assign o_fault           = r_fault;
    assign o_bus_request     = r_bus_request;
    assign o_bus_rw          = r_bus_rw;
    assign o_bus_flush       = r_bus_flush;
    assign o_bus_address     = r_bus_address;
    assign o_bus_byte_enable = r_bus_byte_enable;
    assign o_bus_wdata       = r_bus_wdata;
    assign o_tag             = r_tag;
    assign o_inst_rd         = r_inst_rd;
    assign o_rd              = r_rd;

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Self-checking bench for cpu_memory_stage: directed cases plus randomized
// operations, all compared against a transaction-level model every cycle.
module tb_cpu_memory_stage;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        o_fault;
    logic        o_busy;
    logic [3:0]  i_tag;
    logic [4:0]  i_inst_rd;
    logic [31:0] i_rd;
    logic        i_mem_read;
    logic        i_mem_write;
    logic        i_mem_flush;
    logic [2:0]  i_mem_width;
    logic        i_mem_signed;
    logic [31:0] i_mem_address;
    logic        o_bus_request;
    logic        o_bus_rw;
    logic        o_bus_flush;
    logic [31:0] o_bus_address;
    logic [3:0]  o_bus_byte_enable;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;
    logic [3:0]  o_tag;
    logic [4:0]  o_inst_rd;
    logic [31:0] o_rd;

    cpu_memory_stage #(.TAG_WIDTH(4)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .o_fault(o_fault), .o_busy(o_busy),
        .i_tag(i_tag), .i_inst_rd(i_inst_rd), .i_rd(i_rd),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_flush(i_mem_flush),
        .i_mem_width(i_mem_width), .i_mem_signed(i_mem_signed), .i_mem_address(i_mem_address),
        .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_flush(o_bus_flush),
        .o_bus_address(o_bus_address), .o_bus_byte_enable(o_bus_byte_enable),
        .o_bus_wdata(o_bus_wdata), .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
        .o_tag(o_tag), .o_inst_rd(o_inst_rd), .o_rd(o_rd)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  ird;
        logic [31:0] rd;
        bit          r, w, f;
        logic [2:0]  width;
        bit          sgn;
        logic [31:0] addr;
        int          wait_c;
        logic [31:0] rdata;
    } op_t;

    int n_vec  = 0;
    int n_miss = 0;
    int busy_cnt = 0;
    bit chk_en = 1'b0;

    // Expected observable state, maintained by the model
    logic [3:0]  exp_tag = 4'h0;
    logic [4:0]  exp_inst_rd = 5'd0;
    logic [31:0] exp_rd = 32'h0;
    bit          exp_fault = 1'b0;
    bit          exp_busy = 1'b0;
    bit          exp_req = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    bit          exp_rw = 1'b0;
    bit          exp_flush = 1'b0;
    logic [3:0]  exp_be = 4'h0;
    logic [31:0] exp_wdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit mdl_bad(input int width, input int off);
        if (width == 1) return 1'b0;
        if (width == 2) return (off % 2) != 0;
        if (width == 4) return off != 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] mdl_be(input int width, input int off);
        logic [3:0] be = 4'h0;
        for (int i = 0; i < width; i++) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] mdl_wdata(input int width, input logic [31:0] rd);
        if (width == 1) return {24'h0, rd[7:0]} * 32'h0101_0101;
        if (width == 2) return {16'h0, rd[15:0]} * 32'h0001_0001;
        return rd;
    endfunction

    function automatic logic [31:0] mdl_load(input int width, input int off, input bit sgn,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] mask;
        if (width == 4) return rdata;
        mask = (width == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rdata >> (8 * off)) & mask;
        if (sgn && v[8 * width - 1]) v = v | ~mask;
        return v;
    endfunction

    // Compare DUT against model on every falling edge
    always @(negedge i_clock) begin
        if (chk_en) begin
            if (o_busy === 1'b1) busy_cnt++;
            check("tag",     32'(o_tag),         32'(exp_tag));
            check("inst_rd", 32'(o_inst_rd),     32'(exp_inst_rd));
            check("rd",      o_rd,               exp_rd);
            check("fault",   32'(o_fault),       32'(exp_fault));
            check("busy",    32'(o_busy),        32'(exp_busy));
            check("bus_req", 32'(o_bus_request), 32'(exp_req));
            if (exp_req) begin
                check("bus_addr",  o_bus_address,      exp_addr);
                check("bus_rw",    32'(o_bus_rw),      32'(exp_rw));
                check("bus_flush", 32'(o_bus_flush),   32'(exp_flush));
                if (exp_rw) begin
                    check("bus_be",    32'(o_bus_byte_enable), 32'(exp_be));
                    check("bus_wdata", o_bus_wdata,            exp_wdata);
                end
            end
        end
    end

    function automatic logic [3:0] new_tag();
        return exp_tag + 4'($urandom_range(1, 15));
    endfunction

    function automatic op_t mk(input logic [3:0] tag, input logic [31:0] rd, input bit r,
                               input bit w, input bit f, input logic [2:0] width, input bit sgn,
                               input logic [31:0] addr, input int wc, input logic [31:0] rdata);
        op_t op;
        op.tag = tag; op.ird = 5'($urandom); op.rd = rd;
        op.r = r; op.w = w; op.f = f; op.width = width; op.sgn = sgn;
        op.addr = addr; op.wait_c = wc; op.rdata = rdata;
        return op;
    endfunction

    task automatic drive(input op_t op);
        i_tag = op.tag; i_inst_rd = op.ird; i_rd = op.rd;
        i_mem_read = op.r; i_mem_write = op.w; i_mem_flush = op.f;
        i_mem_width = op.width; i_mem_signed = op.sgn; i_mem_address = op.addr;
        i_bus_ready = 1'b0; i_bus_rdata = $urandom;
    endtask

    // Present one op (called 1 time unit after a rising edge) and carry it to retirement
    task automatic run_op(input op_t op);
        bit mem;
        bit bad;
        int off;
        mem = op.r || op.w || op.f;
        off = int'(op.addr[1:0]);
        bad = mem && mdl_bad(int'(op.width), off);
        drive(op);
        exp_busy = mem;
        @(posedge i_clock); #1;
        if (!mem || bad) begin
            exp_tag = op.tag; exp_inst_rd = op.ird;
            exp_rd = mem ? 32'h0 : op.rd;
            if (bad) exp_fault = 1'b1;
            exp_busy = 1'b0;
            return;
        end
        exp_req   = 1'b1;
        exp_addr  = op.addr & 32'hFFFF_FFFC;
        exp_rw    = op.w;
        exp_flush = !op.w && !op.r;
        exp_be    = mdl_be(int'(op.width), off);
        exp_wdata = mdl_wdata(int'(op.width), op.rd);
        repeat (op.wait_c) begin
            i_bus_rdata = $urandom;
            @(posedge i_clock); #1;
        end
        i_bus_ready = 1'b1; i_bus_rdata = op.rdata;
        @(posedge i_clock); #1;
        i_bus_ready = 1'b0;
        exp_req = 1'b0;
        exp_tag = op.tag; exp_inst_rd = op.ird;
        exp_rd = (op.r && !op.w) ? mdl_load(int'(op.width), off, op.sgn, op.rdata) : op.rd;
        exp_busy = 1'b0;
    endtask

    // A cycle with no new op: tag held, other inputs and ready are noise
    task automatic idle_cycle();
        i_tag = exp_tag; i_inst_rd = 5'($urandom); i_rd = $urandom;
        i_mem_read = 1'($urandom); i_mem_write = 1'($urandom); i_mem_flush = 1'($urandom);
        i_mem_width = 3'($urandom); i_mem_signed = 1'($urandom); i_mem_address = $urandom;
        i_bus_ready = 1'($urandom); i_bus_rdata = $urandom;
        exp_busy = 1'b0;
        @(posedge i_clock); #1;
    endtask

    op_t op;
    int  kind, wsel;

    initial begin
        i_reset = 1'b1; i_tag = 4'h0; i_inst_rd = 5'd0; i_rd = 32'h0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_flush = 1'b0;
        i_mem_width = 3'd0; i_mem_signed = 1'b0; i_mem_address = 32'h0;
        i_bus_ready = 1'b0; i_bus_rdata = 32'h0;
        @(posedge i_clock); #1;
        chk_en = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        check("reset_tag", 32'(o_tag), 32'h0);
        check("reset_req", 32'(o_bus_request), 32'h0);

        // Pin the model against hand-computed values
        check("model_be",    32'(mdl_be(1, 1)),        32'h2);
        check("model_wdata", mdl_wdata(1, 32'hA5),     32'hA5A5_A5A5);
        check("model_sload", mdl_load(1, 3, 1'b1, 32'h80FF_FF7F), 32'hFFFF_FF80);
        check("model_hload", mdl_load(2, 2, 1'b0, 32'h9ABC_1234), 32'h0000_9ABC);

        // Back-to-back pass-throughs
        run_op(mk(4'h1, 32'h11, 0, 0, 0, 3'd4, 0, 32'h0, 0, 32'h0));
        check("pt1_tag", 32'(o_tag), 32'h1);
        run_op(mk(4'h2, 32'h22, 0, 0, 0, 3'd4, 0, 32'h0, 0, 32'h0));
        run_op(mk(4'h3, 32'h33, 0, 0, 0, 3'd4, 0, 32'h0, 0, 32'h0));
        check("pt3_rd", o_rd, 32'h33);

        // Signed byte load, three wait states
        busy_cnt = 0;
        run_op(mk(4'h4, 32'h0, 1, 0, 0, 3'd1, 1, 32'h1003, 3, 32'h80FF_FF7F));
        check("sload_rd", o_rd, 32'hFFFF_FF80);
        check("sload_busy_cycles", 32'(busy_cnt), 32'd5);

        // Unsigned half load, ready immediately
        busy_cnt = 0;
        run_op(mk(4'h5, 32'h0, 1, 0, 0, 3'd2, 0, 32'h2002, 0, 32'h9ABC_1234));
        check("hload_rd", o_rd, 32'h0000_9ABC);
        check("hload_busy_cycles", 32'(busy_cnt), 32'd2);

        // Byte store
        run_op(mk(4'h6, 32'hA5, 0, 1, 0, 3'd1, 0, 32'h3001, 2, 32'h0));
        check("store_rd", o_rd, 32'hA5);

        // Misaligned word read
        run_op(mk(4'h7, 32'h1234, 1, 0, 0, 3'd4, 0, 32'h4002, 0, 32'h0));
        check("mis_fault", 32'(o_fault), 32'h1);
        check("mis_rd", o_rd, 32'h0);
        check("mis_tag", 32'(o_tag), 32'h7);

        // Randomized operations with random idle gaps
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            op = mk(new_tag(), $urandom, 0, 0, 0, 3'd4, 1'($urandom), $urandom,
                    $urandom_range(0, 4), $urandom);
            kind = $urandom_range(0, 9);
            if (kind >= 3 && kind < 6) op.r = 1'b1;
            else if (kind >= 6 && kind < 8) op.w = 1'b1;
            else if (kind == 8) op.f = 1'b1;
            else if (kind == 9) begin op.r = 1'($urandom); op.w = 1'($urandom); op.f = 1'b1; end
            wsel = $urandom_range(0, 9);
            op.width = (wsel < 3) ? 3'd1 : (wsel < 6) ? 3'd2 : (wsel < 9) ? 3'd4 : 3'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (op.width == 3'd2) op.addr[0] = 1'b0;
                if (op.width == 3'd4) op.addr[1:0] = 2'b00;
            end
            run_op(op);
        end
        check("fault_sticky", 32'(o_fault), 32'h1);

        // Reset while a read waits for ready
        op = mk(new_tag(), 32'h0, 1, 0, 0, 3'd4, 0, 32'h6000, 0, 32'h0);
        drive(op);
        exp_busy = 1'b1;
        @(posedge i_clock); #1;
        exp_req = 1'b1; exp_addr = 32'h6000; exp_rw = 1'b0; exp_flush = 1'b0;
        @(posedge i_clock); #1;
        i_reset = 1'b1;
        @(posedge i_clock); #1;
        i_reset = 1'b0; i_tag = 4'h0;
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_flush = 1'b0;
        exp_tag = 4'h0; exp_inst_rd = 5'd0; exp_rd = 32'h0; exp_fault = 1'b0;
        exp_req = 1'b0; exp_busy = 1'b0;
        check("rst_req",   32'(o_bus_request), 32'h0);
        check("rst_fault", 32'(o_fault),       32'h0);
        check("rst_tag",   32'(o_tag),         32'h0);
        idle_cycle();

        run_op(mk(new_tag(), 32'h0, 1, 0, 0, 3'd4, 0, 32'h5000, 1, 32'hDEAD_BEEF));
        check("post_rst_load", o_rd, 32'hDEAD_BEEF);

        @(posedge i_clock); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/cpu_memory_stage.md
Name: cpu_memory_stage

Overview:
- Pipeline stage directly after execute; consumes the execute output record and drives i_memory_busy back to execute.
- Performs loads, stores and cache flushes on the CPU data bus.
- Passes non-memory results through to writeback, formats sub-word loads, and generates byte-lane stores.
- Publishes a tagged writeback record for the next stage.

Parameters:
- TAG_WIDTH, 4, width of the instruction tag used for new-op detection.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- o_fault  out  1  sticky misaligned-access fault
- o_busy  out  1  stall to execute stage (feeds its i_memory_busy)
- i_tag  in  TAG_WIDTH  execute record tag
- i_inst_rd  in  5  destination register index
- i_rd  in  32  execute result / store data
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_mem_flush  in  1  cache flush request
- i_mem_width  in  3  access width in bytes: 1, 2 or 4
- i_mem_signed  in  1  sign-extend sub-word load
- i_mem_address  in  32  effective address
- o_bus_request  out  1  bus transaction active
- o_bus_rw  out  1  1 = write
- o_bus_flush  out  1  flush transaction
- o_bus_address  out  32  word-aligned address (low 2 bits zero)
- o_bus_byte_enable  out  4  write lane enables
- o_bus_wdata  out  32  lane-shifted write data
- i_bus_ready  in  1  transaction complete, i_bus_rdata valid this cycle
- i_bus_rdata  in  32  read word
- o_tag  out  TAG_WIDTH  writeback record tag
- o_inst_rd  out  5  writeback register index
- o_rd  out  32  writeback value

Behaviour:
- Reset: state IDLE; all outputs 0; tag register 0.
- New op: i_tag != o_tag while state is IDLE. The block latches all inputs that cycle, because execute inputs are only held while o_busy is high.
- o_busy is combinational: (state != IDLE) || (new op && (i_mem_read || i_mem_write || i_mem_flush)).
- Pass-through (no read/write/flush): in the next cycle, o_rd <= i_rd, o_inst_rd <= i_inst_rd, o_tag <= i_tag. Latency is 1 cycle with no bus activity. Back-to-back pass-throughs sustain one per cycle.
- Alignment check:
  - A halfword with address[0] = 1 is misaligned.
  - A word with address[1:0] != 0 is misaligned.
  - A misaligned access sets o_fault (sticky until reset), issues no bus request, and retires the op in 1 cycle with o_rd = 0 and o_tag updated, so the pipeline cannot deadlock.
- States: IDLE, READ, WRITE, FLUSH.
  - IDLE -> READ / WRITE / FLUSH on a new op. Priority is write > read > flush.
  - In READ / WRITE / FLUSH, o_bus_request is held high and address, rw, byte enables and wdata are held stable until i_bus_ready is sampled high.
  - On i_bus_ready the state returns to IDLE, the record is updated that same edge, and o_bus_request drops on the following cycle.
  - Minimum memory-op latency: 1 cycle to issue plus bus wait plus 1 cycle.
- Store lanes, with off = address[1:0]:
  - byte: enable = 1 << off; wdata = {4{i_rd[7:0]}}.
  - half: enable = 4'b0011 << off; wdata = {2{i_rd[15:0]}}.
  - word: enable = 4'b1111; wdata = i_rd.
  - Stores write o_rd <= the latched i_rd (store data), matching the execute convention.
- Load extraction: select the byte or halfword from i_bus_rdata at the offset, then sign-extend if i_mem_signed, else zero-extend. Word loads pass through unchanged.
- Flush: o_bus_flush = 1, o_bus_rw = 0, byte enables 0. o_rd <= latched i_rd.
- An invalid width (not 1, 2 or 4) with a memory op is treated as misaligned: set o_fault.
- Reset mid-transaction: state returns to IDLE and o_bus_request drops on the next edge. The bus is required to discard the transaction.
- A tag change on the input while state is not IDLE is ignored: execute is stalled, so this must not happen. The block uses only its latched copy.

Test Plan:
- Pass-through: tags 1, 2, 3 in consecutive cycles with rd 0x11, 0x22, 0x33 and no mem flags -> o_tag follows one cycle later, o_busy stays 0, o_bus_request never asserted.
- Signed byte load: addr 0x1003, width 1, signed, bus returns 0x80FFFF7F after 3 wait cycles -> o_busy high 5 cycles, o_rd = 0xFFFFFF80, bus address 0x1000.
- Unsigned half load: addr 0x2002, width 2, rdata 0x9ABC1234, ready immediately -> o_rd = 0x00009ABC, 2-cycle latency.
- Byte store: addr 0x3001, rd 0x000000A5 -> byte_enable 4'b0010, wdata 0xA5A5A5A5, rw 1, held until ready.
- Misaligned word: addr 0x4002, width 4, read -> o_fault = 1, no request, o_tag updated, o_rd = 0; fault persists until reset.
- Reset while READ waits on ready -> request drops next cycle, all outputs 0, next new op proceeds normally.
